// File: rtl/pwm_dec_pkg.sv
// Shared definitions for the PWM duty-cycle decoder.
//
// Contents:
//   DefaultDw   - default Dout width; the PWM period is 2**DW clocks
//   dec_state_e - decoder FSM states (idle acquisition, windowed measurement)

package pwm_dec_pkg;

    localparam int unsigned DefaultDw = 8;

    // One-hot codes so that any other pattern is detectably illegal and can be
    // steered back to idle.
    typedef enum logic [1:0] {
        StIdle    = 2'b01,
        StMeasure = 2'b10
    } dec_state_e;

endpackage

// File: rtl/pwm_sync.sv
// PWM input sampler and rising-edge detector.
//
// Build option: PWM_DEC_SYNC_EN
//   defined   - PWM input passes a 2-flop synchronizer (2-cycle latency to s)
//   undefined - PWM input is registered once (1-cycle latency to s); only for
//               sources already synchronous to clk_i
//
// Ports:
//   clk_i  - clock, rising edge
//   rst_i  - asynchronous active-high reset, clears every flop
//   pwm_i  - raw PWM input
//   s      - sampled PWM level
//   rise   - s is high this cycle and was low the cycle before

module pwm_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic pwm_i,
    output logic s,
    output logic rise
);

    logic prev_q;

`ifdef PWM_DEC_SYNC_EN
    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= pwm_i;
            sync_q <= meta_q;
        end
    end

    assign s = sync_q;
`else
    logic samp_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            samp_q <= 1'b0;
        end else begin
            samp_q <= pwm_i;
        end
    end

    assign s = samp_q;
`endif

    // Edge-detect flop holds the previous sampled level.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= s;
        end
    end

    assign rise = s & ~prev_q;

endmodule

// File: rtl/pwm_decoder.sv
// PWM duty-cycle decoder.
//
// Recovers the duty value D from a PWM stream that is high for the first D
// cycles of every 2**DW-cycle period. After acquisition the decoder counts high
// cycles over back-to-back 2**DW-cycle windows aligned to the source's rising
// edge and reports each window's count.
//
// Build option: PWM_DEC_SYNC_EN selects a 2-flop input synchronizer instead of
// a single sampling flop (see pwm_sync). Decoded values are the same in both
// builds; only absolute timing shifts by one cycle.
//
// Ports:
//   CLK    - clock, rising edge
//   aRSTin - asynchronous active-high reset
//   PWMin  - PWM input
//   Dout   - last decoded duty value (registered)
//   VALID  - one-cycle pulse when Dout is updated
//   LOCK   - high while windows are aligned to the source period
//   ERR    - one-cycle pulse on a protocol violation

module pwm_decoder
    import pwm_dec_pkg::*;
#(
    parameter int unsigned DW = DefaultDw
) (
    input  logic          CLK,
    input  logic          aRSTin,
    input  logic          PWMin,
    output logic [DW-1:0] Dout,
    output logic          VALID,
    output logic          LOCK,
    output logic          ERR
);

    // A full period's worth of cycles, i.e. 2**DW in DW+1 bits.
    localparam logic [DW:0]   FullCnt = {1'b1, {DW{1'b0}}};
    localparam logic [DW-1:0] LastWin = {DW{1'b1}};
    localparam logic [DW:0]   OneCnt  = {{DW{1'b0}}, 1'b1};
    localparam logic [DW-1:0] OneWin  = {{(DW-1){1'b0}}, 1'b1};

    logic s;
    logic rise;

    pwm_sync u_sync (
        .clk_i (CLK),
        .rst_i (aRSTin),
        .pwm_i (PWMin),
        .s     (s),
        .rise  (rise)
    );

    dec_state_e    state_q, state_d;
    logic [DW-1:0] win_q, win_d;      // index of the current cycle in the window
    logic [DW:0]   hi_q, hi_d;        // high cycles seen before the current cycle
    logic [DW:0]   run_q, run_d;      // idle: cycles already spent at run_lvl_q
    logic          run_lvl_q, run_lvl_d;
    logic [DW-1:0] dout_q, dout_d;
    logic          valid_q, valid_d;
    logic          lock_q, lock_d;
    logic          err_q, err_d;

    logic [DW:0]   hi_cur;            // window count including the current cycle
    logic [DW:0]   run_cur;           // run length including the current cycle

    assign hi_cur  = hi_q + {{DW{1'b0}}, s};
    assign run_cur = (s == run_lvl_q) ? (run_q + OneCnt) : OneCnt;

    always_comb begin
        state_d   = state_q;
        win_d     = win_q;
        hi_d      = hi_q;
        run_d     = run_q;
        run_lvl_d = run_lvl_q;
        dout_d    = dout_q;
        valid_d   = 1'b0;
        lock_d    = lock_q;
        err_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (rise) begin
                    // The rising cycle is window index 0 and already counts as high.
                    state_d   = StMeasure;
                    win_d     = OneWin;
                    hi_d      = OneCnt;
                    run_d     = '0;
                    run_lvl_d = s;
                end else begin
                    run_lvl_d = s;
                    if (run_cur == FullCnt) begin
                        run_d = '0;
                        if (s) begin
                            // Stuck high for a whole period: no frame to decode.
                            err_d  = 1'b1;
                            lock_d = 1'b0;
                        end else begin
                            // Low for a whole period is a valid duty of zero.
                            dout_d  = '0;
                            valid_d = 1'b1;
                            lock_d  = 1'b1;
                        end
                    end else begin
                        run_d = run_cur;
                    end
                end
            end

            StMeasure: begin
                if (rise && (win_q != '0)) begin
                    // Edge off the expected boundary: drop the window and realign
                    // on this edge.
                    err_d  = 1'b1;
                    lock_d = 1'b0;
                    win_d  = OneWin;
                    hi_d   = OneCnt;
                end else if (win_q == LastWin) begin
                    win_d   = '0;
                    hi_d    = '0;
                    valid_d = 1'b1;
                    if (hi_cur == FullCnt) begin
                        // Every cycle high cannot be a legal duty; saturate and flag.
                        dout_d = '1;
                        err_d  = 1'b1;
                        lock_d = 1'b0;
                    end else begin
                        dout_d = hi_cur[DW-1:0];
                        lock_d = 1'b1;
                    end
                end else begin
                    win_d = win_q + OneWin;
                    hi_d  = hi_cur;
                end
            end

            default: begin
                state_d   = StIdle;
                win_d     = '0;
                hi_d      = '0;
                run_d     = '0;
                run_lvl_d = 1'b0;
                lock_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge aRSTin) begin
        if (aRSTin) begin
            state_q   <= StIdle;
            win_q     <= '0;
            hi_q      <= '0;
            run_q     <= '0;
            run_lvl_q <= 1'b0;
            dout_q    <= '0;
            valid_q   <= 1'b0;
            lock_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            win_q     <= win_d;
            hi_q      <= hi_d;
            run_q     <= run_d;
            run_lvl_q <= run_lvl_d;
            dout_q    <= dout_d;
            valid_q   <= valid_d;
            lock_q    <= lock_d;
            err_q     <= err_d;
        end
    end

    assign Dout  = dout_q;
    assign VALID = valid_q;
    assign LOCK  = lock_q;
    assign ERR   = err_q;

endmodule

// File: doc/pwm_decoder.md
PWM_DECODER -- requirements
Module: pwm_decoder

Interface
REQ-001 Parameter: DW, default 8, Dout width; the PWM period SHALL be 2^DW clocks.
REQ-002 CLK  input  1  sole clock; all state SHALL update on the rising edge.
REQ-003 aRSTin  input  1  asynchronous, active-high reset.
REQ-004 PWMin  input  1  PWM from the lab_QMS3 generator, or any source with the same frame: high for the first D cycles of each 2^DW-cycle period, 0 <= D <= 2^DW-1.
REQ-005 Dout  output  DW  last decoded duty value, registered.
REQ-006 VALID  output  1  one-cycle pulse when Dout is updated.
REQ-007 LOCK  output  1  high while windows are aligned to the source period.
REQ-008 ERR  output  1  one-cycle pulse on a protocol violation.

Function
REQ-009 s = PWMin after the sampling stage (REQ-027/028); rise = s & ~s_prev.
REQ-010 States: IDLE, MEASURE. An encoding beyond these SHALL recover to IDLE.
REQ-011 IDLE: a run counter SHALL count consecutive cycles in which s keeps the same level; it SHALL clear on every level change.
REQ-012 IDLE with rise: go to MEASURE; that cycle is window index win=0, with hi=1.
REQ-013 IDLE with s low for 2^DW consecutive cycles: Dout<=0, VALID pulse, LOCK<=1; remain in IDLE and restart the run count.
REQ-014 IDLE with s high for 2^DW consecutive cycles (stuck high): ERR pulse, LOCK<=0, Dout unchanged, restart the run count.
REQ-015 MEASURE: each cycle win<=win+1 (mod 2^DW) and hi<=hi+s, hi being DW+1 bits wide.
REQ-016 On the win=2^DW-1 cycle, hi including the current s SHALL be the window result.
REQ-017 Latency: on the edge after the last window cycle, Dout<=result, VALID=1 for exactly one cycle, LOCK<=1.
REQ-018 Result = 2^DW (every cycle high): Dout<=2^DW-1 (saturated), ERR pulse together with VALID.
REQ-019 Windows SHALL run back-to-back; at win=0 rise is expected but not required (s low at win=0 means a new duty of 0, decoded via REQ-016).
REQ-020 Rise at win!=0 (glitch or period mismatch): ERR pulse, LOCK<=0, no VALID; restart the window at that cycle (win=0, hi=1).
REQ-021 MEASURE with a complete window of result 0, then s low through the next window: Dout<=0 each window; stay in MEASURE.
REQ-022 Simultaneous window end and rise at win=0 of the next window: the VALID for the old window SHALL still issue; the new window starts normally.

Reset
REQ-023 aRSTin high SHALL immediately force: state=IDLE, win=0, hi=0, run counter=0, sampler flops=0, Dout=0, VALID=0, LOCK=0, ERR=0.
REQ-024 Reset mid-window SHALL discard the partial measurement; no VALID or ERR for that window.
REQ-025 After release, the first output SHALL follow a full IDLE acquisition (REQ-012/013).

Configuration
REQ-026 The macro is PWM_DEC_SYNC_EN.
REQ-027 Defined: PWMin passes a 2-flop synchronizer and then the edge-detect flop; PWMin-to-s latency is 2 cycles.
REQ-028 Undefined: PWMin is registered once (1-cycle latency), for synchronous on-chip sources only.
REQ-029 Decoded values SHALL be identical in both builds; only absolute timing shifts.

Structure
REQ-030 Shared package pwm_dec_pkg SHALL hold the state enum (IDLE, MEASURE) and the default DW constant.
REQ-031 Sub-module pwm_sync SHALL contain the sampler/synchronizer (REQ-027/028) and the edge detector, with outputs s and rise.

Verification
REQ-032 Reset, then generator Din=16 for 768 cycles -> LOCK=1 after the first full window; VALID every 256 cycles with Dout=16.
REQ-033 Din=0 -> after 256 low cycles VALID with Dout=0, repeating every 256 cycles; ERR never asserted.
REQ-034 Din=255 -> Dout=255 each window; a forced PWMin high for 300 cycles -> ERR pulse, LOCK=0.
REQ-035 Din 32 -> 128 at a period boundary -> one window yields 32, the next yields 128; no ERR.
REQ-036 Inject a 1-cycle high glitch at win=100 -> ERR pulse, LOCK=0, no VALID for that window; relock with correct Dout within 2 periods.
REQ-037 Assert aRSTin at win=50 -> all outputs 0 immediately; after release, Dout=16 only after reacquisition, in both PWM_DEC_SYNC_EN builds.
